// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its write-back controller.
// Scoreboard counters are CNT_W bits wide and saturate at CNT_MAX.
package regfile_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = 2'd3;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back, register-file and claim bundle.
// Master drives requests and claims; slave is the arbiter.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = regfile_pkg::ADDR_W,
  parameter int DW      = regfile_pkg::DATA_W
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  WriteEnable;
  logic [AW-1:0]         write_address;
  logic [DW-1:0]         write_data_in;
  logic                  claim_valid;
  logic [AW-1:0]         claim_addr;
  logic                  claim_ready;
  logic [NUM_REGS-1:0]   pending;

  modport master (
    output req_valid, req_addr, req_data,
    output claim_valid, claim_addr,
    input  req_ready, claim_ready, pending,
    input  WriteEnable, write_address, write_data_in
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    input  claim_valid, claim_addr,
    output req_ready, claim_ready, pending,
    output WriteEnable, write_address, write_data_in
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or above i_ptr, wrapping.
// Produces a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);
  logic          w_found;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_pos;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N))
        w_sum = w_sum - (PW+1)'(N);
      w_pos = w_sum[PW-1:0];
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: round-robin share of the register file write
// port plus a per-register pending-write scoreboard for hazard checks.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = regfile_pkg::ADDR_W,
  parameter int DW      = regfile_pkg::DATA_W
) (
  input  logic clock,
  input  logic reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_xfer;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_data;

  logic               r_we;
  logic [AW-1:0]      r_waddr;
  logic [DW-1:0]      r_wdata;

  cnt_t               r_cnt [NUM_REGS];
  logic               w_claim_ready;
  logic               w_claim;
  logic               w_retire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign bus.req_ready = w_gnt;
  assign w_xfer        = |w_gnt;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = bus.req_addr[i*AW +: AW];
        w_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      if (w_idx == PW'(NUM_REQ-1))
        r_ptr <= '0;
      else
        r_ptr <= w_idx + 1'b1;
    end
  end

  // Address and data hold between transfers; only the enable pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
    end
  end

  assign bus.WriteEnable   = r_we;
  assign bus.write_address = r_waddr;
  assign bus.write_data_in = r_wdata;

  assign w_claim_ready = (bus.claim_addr == '0) ||
                         (r_cnt[bus.claim_addr] != CNT_MAX);
  assign bus.claim_ready = w_claim_ready;

  assign w_claim  = bus.claim_valid & w_claim_ready &
                    (bus.claim_addr != '0);
  assign w_retire = r_we & (r_waddr != '0);

  // Register 0 never sees inc/dec, so its counter stays at zero.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic w_inc;
    logic w_dec;

    assign w_inc = w_claim  && (bus.claim_addr == AW'(r));
    assign w_dec = w_retire && (r_waddr == AW'(r));

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)
        r_cnt[r] <= '0;
      else if (w_inc && !w_dec)
        r_cnt[r] <= r_cnt[r] + 1'b1;
      else if (w_dec && !w_inc && (r_cnt[r] != '0))
        r_cnt[r] <= r_cnt[r] - 1'b1;
    end

    assign bus.pending[r] = (r_cnt[r] != '0);
  end

  always @(posedge clock) begin
    if (reset && w_retire)
      assert (r_cnt[r_waddr] != '0)
        else $error("retire of idle register %0d", r_waddr);
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a behavioural model
// of grant order, write-back timing and per-register write counts.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors  = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(3), .AW(5), .DW(32)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(3), .AW(5), .DW(32)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          cnt_m  [32];
  int          credit [32];
  int          ptr_m;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  function automatic int mgrant(input logic [2:0] v);
    for (int k = 0; k < 3; k++)
      if (v[(ptr_m + k) % 3]) return (ptr_m + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] oh(input int g);
    return (g < 0) ? 3'b000 : (3'b001 << g);
  endfunction

  function automatic logic [31:0] mpend();
    logic [31:0] p;
    p = '0;
    for (int r = 1; r < 32; r++) p[r] = (cnt_m[r] != 0);
    return p;
  endfunction

  function automatic logic mcr(input int a);
    return (a == 0) || (cnt_m[a] != 3);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      cnt_m[r]  = 0;
      credit[r] = 0;
    end
    ptr_m = 0;
    exp_we = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic idle();
    bus.req_valid   = '0;
    bus.claim_valid = 1'b0;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic tick();
    int g;
    int a;
    logic ok;
    g  = mgrant(bus.req_valid);
    a  = int'(bus.claim_addr);
    ok = bus.claim_valid && mcr(a);
    if (exp_we && exp_addr != 0 && cnt_m[exp_addr] > 0)
      cnt_m[exp_addr]--;
    if (ok && a != 0) begin
      cnt_m[a]++;
      credit[a]++;
    end
    exp_we = (g >= 0);
    if (g >= 0) begin
      exp_addr = bus.req_addr[g*5 +: 5];
      exp_data = bus.req_data[g*32 +: 32];
      ptr_m = (g + 1) % 3;
      if (exp_addr != 0) credit[exp_addr]--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.claim_addr = 5'd7;
    model_clear();
    repeat (2) @(negedge clk);
    bus.req_valid = 3'b110;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b010) begin
      errors++;
      $display("FAIL reset_ready: got %b want 010", bus.req_ready);
    end
    vectors++;
    if (bus.WriteEnable !== 1'b0 || bus.write_address !== 5'd0 ||
        bus.write_data_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_wport: got %b %h %h want 0 00 0",
               bus.WriteEnable, bus.write_address, bus.write_data_in);
    end
    vectors++;
    if (bus.pending !== 32'd0 || bus.claim_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sb: got %h %b want 0 1",
               bus.pending, bus.claim_ready);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd5;
    tick();
    @(negedge clk);
    bus.claim_valid = 1'b0;
    bus.req_valid = 3'b001;
    bus.req_addr[4:0]  = 5'd5;
    bus.req_data[31:0] = 32'hDEADBEEF;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL single_ready: got %b want 001", bus.req_ready);
    end
    tick();
    vectors++;
    if (bus.WriteEnable !== 1'b1 || bus.write_address !== 5'd5 ||
        bus.write_data_in !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: got %b %h %h want 1 05 deadbeef",
               bus.WriteEnable, bus.write_address, bus.write_data_in);
    end
    @(negedge clk);
    idle();
    tick();
    vectors++;
    if (bus.WriteEnable !== 1'b0 || bus.pending !== mpend()) begin
      errors++;
      $display("FAIL single_after: got %b %h want 0 %h",
               bus.WriteEnable, bus.pending, mpend());
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] a [3];
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      a[i] = 5'(8 + 4*i + $urandom_range(0, 3));
      bus.req_addr[i*5 +: 5] = a[i];
      repeat (2) begin
        @(negedge clk);
        bus.claim_valid = 1'b1;
        bus.claim_addr  = a[i];
        tick();
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.claim_valid = 1'b0;
      bus.req_valid = 3'b111;
      bus.req_data = {$urandom, $urandom, $urandom};
      #1;
      vectors++;
      if (bus.req_ready !== oh(k % 3)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b",
                 k, bus.req_ready, oh(k % 3));
      end
      tick();
      vectors++;
      if (bus.WriteEnable !== 1'b1 || bus.write_address !== a[k % 3] ||
          bus.write_data_in !== exp_data) begin
        errors++;
        $display("FAIL rr_write%0d: got %b %h %h want 1 %h %h", k,
                 bus.WriteEnable, bus.write_address, bus.write_data_in,
                 a[k % 3], exp_data);
      end
    end
    @(negedge clk);
    idle();
    tick();
    vectors++;
    if (bus.WriteEnable !== 1'b0 || bus.pending !== 32'd0) begin
      errors++;
      $display("FAIL rr_drain: got %b %h want 0 0",
               bus.WriteEnable, bus.pending);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd7;
    repeat (3) tick();
    vectors++;
    if (bus.claim_ready !== 1'b0 || bus.pending[7] !== 1'b1) begin
      errors++;
      $display("FAIL sat_full: got %b %b want 0 1",
               bus.claim_ready, bus.pending[7]);
    end
    tick();
    vectors++;
    if (bus.claim_ready !== mcr(7) || bus.claim_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_refuse: got %b want 0", bus.claim_ready);
    end
    @(negedge clk);
    bus.claim_valid = 1'b0;
    bus.req_valid = 3'b010;
    bus.req_addr[9:5] = 5'd7;
    tick();
    @(negedge clk);
    bus.req_valid = 3'b000;
    tick();
    vectors++;
    if (bus.claim_ready !== 1'b1 || bus.pending[7] !== 1'b1) begin
      errors++;
      $display("FAIL sat_retire: got %b %b want 1 1",
               bus.claim_ready, bus.pending[7]);
    end
    @(negedge clk);
    bus.req_valid = 3'b010;
    repeat (2) tick();
    @(negedge clk);
    idle();
    tick();
    vectors++;
    if (bus.pending[7] !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: got %b want 0", bus.pending[7]);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd9;
    tick();
    @(negedge clk);
    bus.claim_valid = 1'b0;
    bus.req_valid = 3'b001;
    bus.req_addr[4:0] = 5'd9;
    tick();
    @(negedge clk);
    bus.req_valid = 3'b000;
    bus.claim_valid = 1'b1;
    tick();
    @(negedge clk);
    bus.claim_valid = 1'b0;
    #1;
    vectors++;
    if (bus.pending[9] !== 1'b1 || cnt_m[9] != 1) begin
      errors++;
      $display("FAIL same_hold: got %b want 1", bus.pending[9]);
    end
    bus.req_valid = 3'b001;
    tick();
    @(negedge clk);
    idle();
    tick();
    vectors++;
    if (bus.pending[9] !== 1'b0) begin
      errors++;
      $display("FAIL same_clear: got %b want 0", bus.pending[9]);
    end
  endtask

  task automatic test_addr0();
    @(negedge clk);
    bus.req_valid = 3'b100;
    bus.req_addr[14:10]  = 5'd0;
    bus.req_data[95:64] = $urandom;
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd0;
    #1;
    vectors++;
    if (bus.claim_ready !== 1'b1 ||
        bus.req_ready !== oh(mgrant(bus.req_valid))) begin
      errors++;
      $display("FAIL a0_ready: got %b %b want 1 %b", bus.claim_ready,
               bus.req_ready, oh(mgrant(bus.req_valid)));
    end
    tick();
    vectors++;
    if (bus.WriteEnable !== 1'b1 || bus.write_address !== 5'd0 ||
        bus.write_data_in !== exp_data || bus.pending !== 32'd0) begin
      errors++;
      $display("FAIL a0_write: got %b %h %h %h want 1 00 %h 0",
               bus.WriteEnable, bus.write_address, bus.write_data_in,
               bus.pending, exp_data);
    end
    @(negedge clk);
    idle();
    tick();
  endtask

  task automatic test_random();
    int q[$];
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      q.delete();
      for (int r = 1; r < 32; r++) if (credit[r] > 0) q.push_back(r);
      for (int i = 0; i < 3; i++) begin
        bus.req_valid[i] = ($urandom_range(0, 1) == 1);
        bus.req_addr[i*5 +: 5] = (q.size() > 0) ?
          5'(q[$urandom_range(0, q.size()-1)]) : 5'd0;
        bus.req_data[i*32 +: 32] = $urandom;
      end
      bus.claim_valid = ($urandom_range(0, 2) != 0);
      bus.claim_addr  = 5'($urandom_range(0, 12));
      #1;
      vectors++;
      if (bus.req_ready !== oh(mgrant(bus.req_valid)) ||
          bus.claim_ready !== mcr(int'(bus.claim_addr))) begin
        errors++;
        $display("FAIL rnd_comb%0d: got %b %b want %b %b", n,
                 bus.req_ready, bus.claim_ready,
                 oh(mgrant(bus.req_valid)), mcr(int'(bus.claim_addr)));
      end
      tick();
      vectors++;
      if (bus.WriteEnable !== exp_we || bus.pending !== mpend() ||
          (exp_we && (bus.write_address !== exp_addr ||
                      bus.write_data_in !== exp_data))) begin
        errors++;
        $display("FAIL rnd_seq%0d: got %b %h %h %h want %b %h %h %h", n,
                 bus.WriteEnable, bus.write_address, bus.write_data_in,
                 bus.pending, exp_we, exp_addr, exp_data, mpend());
      end
    end
    @(negedge clk);
    idle();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd3;
    tick();
    @(negedge clk);
    bus.claim_valid = 1'b0;
    bus.req_valid = 3'b010;
    bus.req_addr[9:5] = 5'd3;
    tick();
    vectors++;
    if (bus.WriteEnable !== 1'b1 || bus.pending[3] !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got %b %b want 1 1",
               bus.WriteEnable, bus.pending[3]);
    end
    @(negedge clk);
    bus.req_valid = 3'b000;
    rst_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (bus.WriteEnable !== 1'b0 || bus.pending !== 32'd0 ||
        bus.write_address !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b %h %h want 0 0 00",
               bus.WriteEnable, bus.pending, bus.write_address);
    end
    bus.req_addr = '0;
    bus.req_valid = 3'b111;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL mid_held: got %b want 001", bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL mid_first: got %b want 001", bus.req_ready);
    end
    tick();
    vectors++;
    if (bus.WriteEnable !== 1'b1 || bus.write_address !== 5'd0) begin
      errors++;
      $display("FAIL mid_write: got %b %h want 1 00",
               bus.WriteEnable, bus.write_address);
    end
    @(negedge clk);
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_saturation();
    test_same_cycle();
    test_addr0();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
